spi_reg_responder: RTL and testbench
====================================

# spi_reg_responder

SPI-mode-0 responder with a 32 × 8 register file, modelled on the command/data framing of the USB host controller on the Arduino header. The responder sits on the far end of the SoC's `spi0` master (SS_n/MOSI/MISO/SCLK) and lets the Nios II USB driver run against fabric logic in simulation and on hardware without the shield fitted. Fabric logic sets interrupt bits and writes registers through a local host port. A level `irq` output mirrors the `usb_irq` line.

## Interface
Parameters:
- `STATUS_ADDR`, default 25: register returned on MISO during every command byte.
- `IRQ_ADDR`, default 25: interrupt-flag register (SPI write-1-to-clear, host OR-set).
- `IEN_ADDR`, default 26: interrupt-enable register.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock (50 MHz).
- `reset_n` in 1: asynchronous active-low reset.
- `spi_sclk` in 1: SPI clock from the master; asynchronous to `clk`.
- `spi_ss_n` in 1: slave select, active low; asynchronous.
- `spi_mosi` in 1: master-out data; asynchronous.
- `spi_miso` out 1: slave-out data.
- `spi_miso_oe` out 1: MISO output enable; the top level tristates MISO when this is 0.
- `host_wr` in 1: local write strobe.
- `host_addr` in 5: local register address.
- `host_wdata` in 8: local write data.
- `host_rdata` out 8: combinational `reg[host_addr]`.
- `wr_strobe` out 1: one-cycle pulse when an SPI data write commits.
- `wr_addr` out 5: address of the committed SPI write; valid with `wr_strobe`.
- `wr_data` out 8: data of the committed SPI write; valid with `wr_strobe`.
- `irq` out 1: `|(reg[IRQ_ADDR] & reg[IEN_ADDR])`, registered.

## Operation
- **Synchronisers:** `spi_sclk`, `spi_ss_n` and `spi_mosi` each pass through a 2-FF synchroniser. Rise and fall edge detection is done on the synchronised SCLK and SS_n.
- **Framing:** a transaction runs from SS_n falling to SS_n rising.
  - Byte 0 is the command: bits[7:3] = start address, bit1 = 1 for write, 0 for read; bits 2 and 0 are ignored.
  - Each later byte is a data byte. MSB first throughout.
- **States:**
  - IDLE → CMD on synchronised SS_n fall.
  - CMD → DATA on the 8th SCLK rise.
  - DATA → DATA on every further 8th rise.
  - Any state → IDLE on SS_n rise.
  - A 3-bit bit counter is cleared on entry to CMD and wraps every byte.
- **Sampling:** MOSI is sampled on the synchronised SCLK rise. MISO changes on the synchronised SCLK fall.
- **Status byte:** on SS_n fall, load the TX shifter with `reg[STATUS_ADDR]` and drive its MSB.
- **Read (bit1 = 0):**
  - At each byte boundary (8th rise), load the TX shifter with `reg[addr]`, then `addr <= addr+1`.
  - Its MSB appears on the next SCLK fall, so data byte k returns `reg[start+k]`.
- **Write (bit1 = 1):**
  - At each data-byte 8th rise, commit the RX byte to `reg[addr]`, pulse `wr_strobe` with `wr_addr`/`wr_data`, then `addr <= addr+1`.
  - MISO returns 0x00 during write data bytes.
- **Address wrap:** the address increments mod 32 (31 → 0).
- **IRQ register:**
  - SPI write of value v to `IRQ_ADDR` gives `reg &= ~v` (W1C).
  - Host write of v to `IRQ_ADDR` gives `reg |= v`.
  - Host writes to any other address overwrite.
- **Simultaneous events:**
  - On `IRQ_ADDR`, an SPI and a host write in the same cycle give `(old & ~spi) | host`, so the host set wins.
  - On any other address, the SPI write wins and the host write is dropped.
- **Aborted byte:** SS_n rise mid-byte discards the partial byte. No commit and no strobe occur, and the register file is untouched.
- **Output enable:** `spi_miso_oe` = 1 while in CMD or DATA, and 0 in IDLE.

## Timing
- **Reset values:** all 32 registers 0x00, state IDLE, `spi_miso` 0, `spi_miso_oe` 0, `wr_strobe` 0, `wr_addr` 0, `wr_data` 0, `irq` 0.
- **Synchroniser latency:** 2 `clk` cycles plus 1 cycle for edge detect.
  - SCLK must be ≤ `clk`/8: high and low phases ≥ 4 `clk` each.
  - The master must allow ≥ 4 `clk` between SS_n fall and the first SCLK rise.
- **MISO latency:** valid ≤ 4 `clk` after a synchronised SCLK fall (or SS_n fall).
- **Write commit:** `wr_strobe` and the register update occur 3–4 `clk` after the physical 8th SCLK rise. The write is visible on `host_rdata` the following cycle.
- **irq:** updates 1 `clk` after any change to the IRQ or IEN registers.
- **Back-to-back transactions:** SS_n high for ≥ 4 `clk` between transactions is required.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-transaction → all outputs at reset values; `reg[5]` reads 0x00 via the host port; after release, SS_n fall starts a fresh CMD.
- **Burst write with wrap:** SPI command 0xFA (addr 31, write), data 0x11, 0x22 → `reg[31]` = 0x11, `reg[0]` = 0x22; two `wr_strobe` pulses with (31, 0x11), (0, 0x22).
- **Status plus read:** host writes `reg[25]` = 0x04 and `reg[3]` = 0xA5, `reg[4]` = 0x5A. SPI command 0x18 (addr 3, read) plus two dummy bytes → MISO bytes 0x04, 0xA5, 0x5A.
- **Interrupt W1C:**
  - Host sets `IEN` = 0x0C and `IRQ` |= 0x04 → `irq` = 1.
  - SPI write 0x04 to addr 25 → `reg[25]` = 0x00, `irq` = 0.
  - Same cycle host set 0x04 and SPI W1C 0x04 → `reg[25]` = 0x04.
- **Aborted byte:** SPI command 0x52 (addr 10, write), then 5 data bits, then SS_n rise → no `wr_strobe`, `reg[10]` unchanged, `spi_miso_oe` = 0.
- **Collision:** host write `reg[7]` = 0x33 in the same cycle as an SPI commit of 0x44 to `reg[7]` → `reg[7]` = 0x44.

Source files
------------

// File: rtl/spi_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_responder: SPI mode-0 responder fronting a 32 x 8 register file,   |
// | with a local host write port, W1C interrupt flags and a level irq output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_reg_responder #(
  parameter int unsigned STATUS_ADDR = 25,
  parameter int unsigned IRQ_ADDR    = 25,
  parameter int unsigned IEN_ADDR    = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       host_wr,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       irq
);

  localparam logic [4:0] c_status = 5'(STATUS_ADDR);
  localparam logic [4:0] c_irq    = 5'(IRQ_ADDR);
  localparam logic [4:0] c_ien    = 5'(IEN_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Bit 1 of each chain is the synchronised level, bit 2 its one-cycle-old copy.
  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic [4:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic       wr_strobe_q;
  logic [4:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       irq_q;
  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];

  logic       w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic [7:0] w_rx_byte;
  logic       w_spi_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      ss_q   <= {ss_q[1:0], spi_ss_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign w_sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign w_sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign w_ss_fall   = ~ss_q[1] & ss_q[2];
  assign w_ss_rise   = ss_q[1] & ~ss_q[2];
  assign w_rx_byte   = {rx_q, mosi_q[1]};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    addr_d   = addr_q;
    write_d  = write_q;
    w_spi_we = 1'b0;
    if (w_ss_rise) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_ss_fall) begin
            state_d  = ST_CMD;
            bitcnt_d = 3'd0;
            tx_d     = {regs_q[c_status][6:0], 1'b0};
            miso_d   = regs_q[c_status][7];
          end
        end
        ST_CMD, ST_DATA: begin
          if (w_sclk_rise) begin
            rx_d     = w_rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = ST_DATA;
              if (state_q == ST_CMD) begin
                write_d = w_rx_byte[1];
                if (w_rx_byte[1]) begin
                  tx_d   = 8'h00;
                  addr_d = w_rx_byte[7:3];
                end else begin
                  tx_d   = regs_q[w_rx_byte[7:3]];
                  addr_d = w_rx_byte[7:3] + 5'd1;
                end
              end else if (write_q) begin
                w_spi_we = 1'b1;
                tx_d     = 8'h00;
                addr_d   = addr_q + 5'd1;
              end else begin
                tx_d   = regs_q[addr_q];
                addr_d = addr_q + 5'd1;
              end
            end
          end else if (w_sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A colliding host write only survives on the flag register, where it ORs in after the clear.
  always_comb begin
    regs_d = regs_q;
    if (w_spi_we) begin
      if (addr_q == c_irq)
        regs_d[addr_q] = (regs_q[addr_q] & ~w_rx_byte) |
                         ((host_wr && host_addr == addr_q) ? host_wdata : 8'h00);
      else
        regs_d[addr_q] = w_rx_byte;
    end
    if (host_wr && !(w_spi_we && host_addr == addr_q)) begin
      if (host_addr == c_irq)
        regs_d[host_addr] = regs_q[host_addr] | host_wdata;
      else
        regs_d[host_addr] = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      addr_q      <= 5'd0;
      write_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      irq_q       <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wr_strobe_q <= w_spi_we;
      if (w_spi_we) begin
        wr_addr_q <= addr_q;
        wr_data_q <= w_rx_byte;
      end
      irq_q  <= |(regs_q[c_irq] & regs_q[c_ien]);
      regs_q <= regs_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q != ST_IDLE);
  assign host_rdata  = regs_q[host_addr];
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_responder: scoreboard bench driving a mode-0 SPI master and the |
// | host port against a register-file reference model.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_reg_responder;

  localparam int HP = 5;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic       host_wr = 1'b0;
  logic [4:0] host_addr = 5'd0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_regs [32];
  logic [7:0]  txq[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  act_miso[$];
  logic [12:0] exp_wr[$];
  int          inj_byte = -1;
  logic [4:0]  inj_addr = 5'd0;
  logic [7:0]  inj_data = 8'h00;

  spi_reg_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_ss_n   (spi_ss_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: status byte, then either reg[start+k] or zeros with writes applied.
  task automatic model_spi(input int nbytes);
    logic [7:0] c, v;
    logic [4:0] a;
    c = txq[0];
    a = c[7:3];
    exp_miso.push_back(ref_regs[25]);
    for (int k = 1; k < nbytes; k++) begin
      v = txq[k];
      if (c[1]) begin
        exp_miso.push_back(8'h00);
        exp_wr.push_back({a, v});
        if (a == 5'd25) ref_regs[a] = ref_regs[a] & ~v;
        else            ref_regs[a] = v;
        if (k == inj_byte) begin
          if (inj_addr == 5'd25)  ref_regs[25] = ref_regs[25] | inj_data;
          else if (inj_addr != a) ref_regs[inj_addr] = inj_data;
        end
      end else begin
        exp_miso.push_back(ref_regs[a]);
      end
      a = a + 5'd1;
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] v);
    host_addr  = a;
    host_wdata = v;
    host_wr    = 1'b1;
    wait_clk(1);
    host_wr = 1'b0;
    if (a == 5'd25) ref_regs[a] = ref_regs[a] | v;
    else            ref_regs[a] = v;
  endtask

  // Sends nbytes full bytes from txq, then abort_bits bits of the next byte if nonzero.
  task automatic spi_txn(input int nbytes, input int abort_bits);
    logic [7:0] b, r;
    int nb, nbits;
    spi_ss_n = 1'b0;
    wait_clk(HP);
    check("miso_oe_active", 32'(spi_miso_oe), 32'd1);
    nb = nbytes + ((abort_bits > 0) ? 1 : 0);
    for (int k = 0; k < nb; k++) begin
      b = txq[k];
      r = 8'h00;
      nbits = (k < nbytes) ? 8 : abort_bits;
      for (int j = 0; j < nbits; j++) begin
        spi_mosi = b[7-j];
        wait_clk(HP);
        r[7-j] = spi_miso;
        spi_sclk = 1'b1;
        if (j == 7 && k == inj_byte) begin
          // lands the host strobe on the clk edge where the synchronised rise commits
          wait_clk(2);
          host_addr  = inj_addr;
          host_wdata = inj_data;
          host_wr    = 1'b1;
          wait_clk(1);
          host_wr = 1'b0;
          wait_clk(HP - 3);
        end else begin
          wait_clk(HP);
        end
        spi_sclk = 1'b0;
      end
      if (k < nbytes) act_miso.push_back(r);
    end
    wait_clk(HP);
    spi_ss_n = 1'b1;
    wait_clk(6);
    inj_byte = -1;
  endtask

  task automatic check_regs(input string tag);
    wait_clk(2);
    for (int i = 0; i < 32; i++) begin
      host_addr = 5'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), 32'(host_rdata), 32'(ref_regs[i]));
    end
    check({tag, "_irq"}, 32'(irq), 32'(|(ref_regs[25] & ref_regs[26])));
    wait_clk(1);
  endtask

  logic [12:0] mon_e;
  logic [7:0]  mon_a, mon_m;
  always @(negedge clk) begin
    if (reset_n && wr_strobe) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe_unexpected: got addr %0d data %02h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== mon_e) begin
          errors++;
          $display("FAIL wr_commit: got addr %0d data %02h expected addr %0d data %02h",
                   wr_addr, wr_data, mon_e[12:8], mon_e[7:0]);
        end
      end
    end
    if (act_miso.size() > 0) begin
      mon_a = act_miso.pop_front();
      checks++;
      if (exp_miso.size() == 0) begin
        errors++;
        $display("FAIL miso_byte_unexpected: got %02h, none expected", mon_a);
      end else begin
        mon_m = exp_miso.pop_front();
        if (mon_a !== mon_m) begin
          errors++;
          $display("FAIL miso_byte: got %02h expected %02h", mon_a, mon_m);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

  int nhost, nbytes;
  logic [4:0] ra;

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'h00;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(1);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // Burst write wrapping 31 -> 0
    txq = '{8'hFA, 8'h11, 8'h22};
    model_spi(3); spi_txn(3, 0);
    check_regs("burst");

    // Status byte then sequential reads
    host_write(5'd25, 8'h04);
    host_write(5'd3, 8'hA5);
    host_write(5'd4, 8'h5A);
    txq = '{8'h18, 8'h00, 8'h00};
    model_spi(3); spi_txn(3, 0);
    check_regs("read");

    // Interrupt enable, set, W1C and simultaneous set/clear
    host_write(5'd26, 8'h0C);
    host_write(5'd25, 8'h04);
    wait_clk(2);
    check("irq_set", 32'(irq), 32'(|(ref_regs[25] & ref_regs[26])));
    txq = '{8'hCA, 8'h04};
    model_spi(2); spi_txn(2, 0);
    check_regs("w1c");
    inj_byte = 1; inj_addr = 5'd25; inj_data = 8'h04;
    txq = '{8'hCA, 8'h04};
    model_spi(2); spi_txn(2, 0);
    check_regs("w1c_collide");

    // Aborted data byte
    host_write(5'd10, 8'h3C);
    txq = '{8'h52, 8'hFF};
    model_spi(1); spi_txn(1, 5);
    check("abort_miso_oe", 32'(spi_miso_oe), 32'd0);
    check_regs("abort");

    // Host/SPI collision on an ordinary register
    inj_byte = 1; inj_addr = 5'd7; inj_data = 8'h33;
    txq = '{8'h3A, 8'h44};
    model_spi(2); spi_txn(2, 0);
    check_regs("collide");

    // Reset in the middle of a transaction
    host_write(5'd5, 8'h77);
    spi_ss_n = 1'b0;
    wait_clk(HP);
    for (int j = 0; j < 3; j++) begin
      spi_mosi = 1'b1; wait_clk(HP);
      spi_sclk = 1'b1; wait_clk(HP);
      spi_sclk = 1'b0;
    end
    reset_n = 1'b0;
    wait_clk(1);
    check("mrst_miso", 32'(spi_miso), 32'd0);
    check("mrst_miso_oe", 32'(spi_miso_oe), 32'd0);
    check("mrst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("mrst_wr_addr", 32'(wr_addr), 32'd0);
    check("mrst_wr_data", 32'(wr_data), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    host_addr = 5'd5;
    #1;
    check("mrst_reg5", 32'(host_rdata), 32'd0);
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'h00;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(3);
    txq = '{8'h2A, 8'h99};
    model_spi(2); spi_txn(2, 0);
    check_regs("post_rst");

    // Randomised host writes and SPI bursts
    for (int t = 0; t < 40; t++) begin
      nhost = int'($urandom_range(0, 3));
      for (int h = 0; h < nhost; h++) begin
        if ($urandom_range(0, 3) == 0) ra = 5'(25 + $urandom_range(0, 1));
        else                           ra = 5'($urandom_range(0, 31));
        host_write(ra, 8'($urandom));
      end
      txq.delete();
      nbytes = int'($urandom_range(1, 5));
      for (int k = 0; k < nbytes; k++) begin
        if (k == 0 && $urandom_range(0, 3) == 0) txq.push_back({5'd25, 3'($urandom)});
        else                                     txq.push_back(8'($urandom));
      end
      model_spi(nbytes); spi_txn(nbytes, 0);
    end
    check_regs("rand");

    wait_clk(4);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_miso_drained", 32'(exp_miso.size()), 32'd0);
    check("act_miso_drained", 32'(act_miso.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
